uart_midi_tx: RTL and testbench



---
 rtl/uart_midi_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_midi_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_midi_tx.sv
// uart_midi_tx
// Serializes one packed MIDI message per valid/ready handshake onto an 8N1
// UART line, LSB first. The status byte sets how many bytes the message has,
// so only those bytes are sent. Data bytes always go out with bit 7 cleared.
// A status byte with bit 7 clear is rejected: nothing is sent and error_out
// pulses one cycle later.
//
// Ports:
//   clk_in     : system clock, rising edge
//   rst_in     : synchronous active-high reset
//   valid_in   : a message is offered on midi_bytes
//   midi_bytes : [23:16] status, [15:8] data1, [7:0] data2
//   ready_out  : block can accept a message (registered)
//   tx_out     : UART line, idles high (registered)
//   done_out   : one-cycle pulse when the final stop bit completes
//   error_out  : one-cycle pulse after an invalid status byte is accepted
module uart_midi_tx #(
   parameter int CLK_HZ     = 98_333_333,
   parameter int BAUD       = 31_250,
   parameter int MIDI_BYTES = 24
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  valid_in,
   input  logic [MIDI_BYTES-1:0] midi_bytes,
   output logic                  ready_out,
   output logic                  tx_out,
   output logic                  done_out,
   output logic                  error_out
);

   localparam int CPB = CLK_HZ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [2:0]            bit_idx;
   logic [1:0]            byte_idx;
   logic [1:0]            last_idx;
   logic [MIDI_BYTES-1:0] msg_q;
   logic                  err_pending;
   logic [7:0]            cur_byte;
   logic [2:0]            next_bit;

   // Index of the final byte (message length minus one) for a valid status.
   function automatic logic [1:0] last_index(input logic [7:0] status);
      logic [1:0] idx;
      idx = 2'd0;
      case (status[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: idx = 2'd2;
         4'hC, 4'hD:                   idx = 2'd1;
         4'hF: begin
            if (status == 8'hF1 || status == 8'hF3)
               idx = 2'd1;
            else if (status == 8'hF2)
               idx = 2'd2;
            else
               idx = 2'd0;
         end
         default:                      idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Byte currently on the wire; data bytes lose their top bit so a corrupt
   // data value can never be mistaken for a status byte downstream.
   always_comb begin
      cur_byte = msg_q[23:16];
      case (byte_idx)
         2'd0:    cur_byte = msg_q[23:16];
         2'd1:    cur_byte = msg_q[15:8] & 8'h7F;
         default: cur_byte = msg_q[7:0] & 8'h7F;
      endcase
   end

   assign next_bit = bit_idx + 3'd1;

   // Frame sequencer. tx_out is loaded with the value of the upcoming bit on
   // the same edge the state changes, so the line is fully registered and
   // the start bit appears on the accept edge itself.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         byte_idx    <= '0;
         last_idx    <= '0;
         msg_q       <= '0;
         err_pending <= 1'b0;
         ready_out   <= 1'b1;
         tx_out      <= 1'b1;
         done_out    <= 1'b0;
         error_out   <= 1'b0;
      end else begin
         done_out    <= 1'b0;
         error_out   <= err_pending;
         err_pending <= 1'b0;
         case (state)
            IDLE: begin
               ready_out <= 1'b1;
               tx_out    <= 1'b1;
               if (valid_in && ready_out) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  byte_idx <= '0;
                  if (midi_bytes[23]) begin
                     msg_q     <= midi_bytes;
                     last_idx  <= last_index(midi_bytes[23:16]);
                     state     <= START;
                     ready_out <= 1'b0;
                     tx_out    <= 1'b0;
                  end else begin
                     err_pending <= 1'b1;
                  end
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx_out  <= cur_byte[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= STOP;
                     tx_out  <= 1'b1;
                  end else begin
                     bit_idx <= next_bit;
                     tx_out  <= cur_byte[next_bit];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  if (byte_idx < last_idx) begin
                     byte_idx <= byte_idx + 1'b1;
                     state    <= START;
                     tx_out   <= 1'b0;
                  end else begin
                     byte_idx  <= '0;
                     state     <= IDLE;
                     ready_out <= 1'b1;
                     done_out  <= 1'b1;
                     tx_out    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               ready_out <= 1'b1;
               tx_out    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_midi_tx.sv
// tb_uart_midi_tx
// Testbench for uart_midi_tx at CPB = 10. Stimulus pushes expected frames,
// done pulses and error pulses into queues; independent monitors decode the
// UART line and watch the pulse outputs, popping and comparing as the DUT
// produces them. A per-cycle checker compares ready_out and idle tx_out
// against the busy window the model derives from each accept.
module tb_uart_midi_tx;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int TB_CPB = CLK_HZ / BAUD;
   localparam int FRAME  = 10 * TB_CPB;
   localparam int MAXW   = 2000;

   typedef struct {
      logic [7:0] value;
      int         start;
   } frame_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        valid_in;
   logic [23:0] midi_bytes;
   logic        ready_out;
   logic        tx_out;
   logic        done_out;
   logic        error_out;

   int     cyc = 0;
   int     num_checks = 0;
   int     num_errors = 0;
   int     busy_start = 0;
   int     busy_end = 0;
   int     epoch = 0;
   bit     mon_en = 1'b0;
   frame_t exp_frames[$];
   int     exp_done[$];
   int     exp_err[$];

   uart_midi_tx #(
      .CLK_HZ(CLK_HZ),
      .BAUD(BAUD),
      .MIDI_BYTES(24)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .valid_in(valid_in),
      .midi_bytes(midi_bytes),
      .ready_out(ready_out),
      .tx_out(tx_out),
      .done_out(done_out),
      .error_out(error_out)
   );

   // Free-running clock and edge counter; cycle c starts at posedge number c.
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Message length straight from the MIDI status rules; 0 means invalid.
   function automatic int msgLen(input logic [7:0] s);
      if (!s[7]) return 0;
      if (s[7:4] == 4'hC || s[7:4] == 4'hD) return 2;
      if (s[7:4] == 4'hF) begin
         if (s == 8'hF1 || s == 8'hF3) return 2;
         if (s == 8'hF2) return 3;
         return 1;
      end
      return 3;
   endfunction

   // Reference model: everything the line and pulses must show for an
   // accept at edge k.
   task automatic modelExpect(input logic [23:0] msg, input int k);
      int     n;
      frame_t f;
      logic [7:0] b [3];
      b[0] = msg[23:16];
      b[1] = msg[15:8] & 8'h7F;
      b[2] = msg[7:0] & 8'h7F;
      n = msgLen(msg[23:16]);
      if (n == 0) begin
         exp_err.push_back(k + 1);
      end else begin
         for (int i = 0; i < n; i++) begin
            f.value = b[i];
            f.start = k + i * FRAME;
            exp_frames.push_back(f);
         end
         exp_done.push_back(k + n * FRAME);
         busy_start = k;
         busy_end   = k + n * FRAME;
      end
   endtask

   // Offer msg until accepted; k returns the accept edge (-1 on timeout).
   task automatic applyStimulus(input logic [23:0] msg, input bit hold,
                                output int k);
      int waited = 0;
      @(negedge clk_in);
      valid_in   = 1'b1;
      midi_bytes = msg;
      while (!ready_out && waited < MAXW) begin
         @(negedge clk_in);
         waited++;
      end
      if (!ready_out) begin
         num_checks++;
         num_errors++;
         $display("[TB] FAIL accept_timeout: ready_out still 0, expected 1 within %0d cycles", MAXW);
         valid_in = 1'b0;
         k = -1;
         return;
      end
      k = cyc + 1;
      modelExpect(msg, k);
      @(posedge clk_in);
      @(negedge clk_in);
      if (!hold) begin
         valid_in   = 1'b0;
         midi_bytes = 24'($urandom);
      end
   endtask

   // Line decoder: samples each bit mid-period, discards frames cut by reset.
   initial begin
      int         s;
      int         ep;
      logic       start_mid;
      logic       stop_bit;
      logic [7:0] data;
      frame_t     f;
      forever begin
         @(negedge clk_in);
         if (mon_en && tx_out === 1'b0) begin
            s  = cyc;
            ep = epoch;
            repeat (TB_CPB / 2) @(negedge clk_in);
            start_mid = tx_out;
            for (int j = 0; j < 8; j++) begin
               repeat (TB_CPB) @(negedge clk_in);
               data[j] = tx_out;
            end
            repeat (TB_CPB) @(negedge clk_in);
            stop_bit = tx_out;
            if (ep == epoch) begin
               if (exp_frames.size() == 0) begin
                  num_checks++;
                  num_errors++;
                  $display("[TB] FAIL unexpected_frame: got byte 0x%0h at cycle %0d, expected no frame", data, s);
               end else begin
                  f = exp_frames.pop_front();
                  checkOutput("frame_start_cycle", s, f.start);
                  checkOutput("frame_byte", {24'd0, data}, {24'd0, f.value});
                  checkOutput("start_bit_mid", {31'd0, start_mid}, 32'd0);
                  checkOutput("stop_bit", {31'd0, stop_bit}, 32'd1);
               end
            end
         end
      end
   end

   // Per-cycle checks of ready/idle line and the done/error pulse timing.
   always @(negedge clk_in) begin
      bit busy;
      if (mon_en) begin
         busy = (cyc >= busy_start) && (cyc < busy_end);
         checkOutput("ready_out", {31'd0, ready_out}, {31'd0, !busy});
         if (!busy) checkOutput("tx_idle_high", {31'd0, tx_out}, 32'd1);
         if (done_out === 1'b1) begin
            if (exp_done.size() == 0) begin
               num_checks++;
               num_errors++;
               $display("[TB] FAIL unexpected_done: got done_out=1 at cycle %0d, expected 0", cyc);
            end else begin
               checkOutput("done_cycle", cyc, exp_done.pop_front());
            end
         end
         if (error_out === 1'b1) begin
            if (exp_err.size() == 0) begin
               num_checks++;
               num_errors++;
               $display("[TB] FAIL unexpected_error: got error_out=1 at cycle %0d, expected 0", cyc);
            end else begin
               checkOutput("error_cycle", cyc, exp_err.pop_front());
            end
         end
      end
   end

   initial begin
      int         k;
      int         k2;
      int         waited;
      logic [7:0] s;
      rst_in     = 1'b1;
      valid_in   = 1'b0;
      midi_bytes = '0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("reset_ready", {31'd0, ready_out}, 32'd1);
      checkOutput("reset_tx", {31'd0, tx_out}, 32'd1);
      checkOutput("reset_done", {31'd0, done_out}, 32'd0);
      checkOutput("reset_error", {31'd0, error_out}, 32'd0);
      rst_in = 1'b0;
      mon_en = 1'b1;

      $display("[TB] note-on, program change, timing clock, invalid status");
      applyStimulus(24'h903C64, 1'b0, k);
      applyStimulus(24'hC005AA, 1'b0, k);
      applyStimulus(24'hF81234, 1'b0, k);
      applyStimulus(24'h3C6400, 1'b0, k);
      repeat (5) @(negedge clk_in);

      $display("[TB] reset in the middle of a data bit");
      applyStimulus(24'h903C64, 1'b0, k);
      while (cyc < k + 44) @(negedge clk_in);
      rst_in = 1'b1;
      exp_frames.delete();
      exp_done.delete();
      busy_end = k + 45;
      epoch++;
      @(negedge clk_in);
      checkOutput("reset_mid_tx", {31'd0, tx_out}, 32'd1);
      checkOutput("reset_mid_ready", {31'd0, ready_out}, 32'd1);
      rst_in = 1'b0;
      while (cyc < k + FRAME) @(negedge clk_in);
      applyStimulus(24'hF80000, 1'b0, k);

      $display("[TB] back-to-back with valid held high");
      applyStimulus(24'h903C64, 1'b1, k);
      while (cyc < k + 50) @(negedge clk_in);
      midi_bytes = 24'h803C00;
      applyStimulus(24'h803C00, 1'b0, k2);
      checkOutput("back_to_back_accept", k2, k + 3 * FRAME + 1);

      $display("[TB] randomized messages");
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk_in);
         if ($urandom_range(0, 4) == 0)
            s = {1'b0, 7'($urandom)};
         else
            s = {1'b1, 7'($urandom)};
         applyStimulus({s, 16'($urandom)}, 1'b0, k);
      end

      waited = 0;
      while ((exp_frames.size() != 0 || exp_done.size() != 0 || exp_err.size() != 0
              || cyc < busy_end + 2) && waited < MAXW) begin
         @(negedge clk_in);
         waited++;
      end
      checkOutput("frames_left", exp_frames.size(), 0);
      checkOutput("done_left", exp_done.size(), 0);
      checkOutput("error_left", exp_err.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
